// File: rtl/morse_pkg.sv
// morse_pkg: definitions shared by the Morse generator and the key decoder.
//   - Symbol codes: the same 2-bit code that the generator takes on its start input.
//   - Decoder FSM state encoding.
//   - Default element timing of the generator, in milliseconds.
//   - decode_char(): maps a collected element store to a symbol code.
package morse_pkg;

    localparam logic [1:0] SYM_S    = 2'b10;
    localparam logic [1:0] SYM_O    = 2'b01;
    localparam logic [1:0] SYM_NONE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2,
        ST_EMIT  = 2'd3
    } morse_state_t;

    // Generator element timing (ms)
    localparam int unsigned DOT_MS  = 100;
    localparam int unsigned DASH_MS = 400;
    localparam int unsigned GAP_MS  = 50;

    localparam int unsigned PRESC_W = 16;
    localparam int unsigned MS_W    = 11;
    localparam int unsigned CNT_W   = 3;

    // Only clean three-element characters map to a symbol.
    // pattern holds 1 = dash, 0 = dot.
    function automatic logic [1:0] decode_char(input logic [CNT_W-1:0] count,
                                               input logic [2:0]       pattern,
                                               input logic             bad);
        logic [1:0] code;
        code = SYM_NONE;
        if (!bad && count == CNT_W'(3)) begin
            if (pattern == 3'b000)      code = SYM_S;
            else if (pattern == 3'b111) code = SYM_O;
        end
        return code;
    endfunction

endpackage

// File: rtl/morse_ms_timer.sv
// morse_ms_timer: millisecond timer built from a prescaler and a saturating ms counter.
// Ports:
//   CLK  in   system clock
//   RST  in   synchronous active-high reset
//   clr  in   clears prescaler and ms counter on the next edge
//   ms   out  elapsed whole milliseconds since the last clear, saturates at 2047
module morse_ms_timer
    import morse_pkg::*;
#(
    parameter logic [PRESC_W-1:0] T1MS = 16'd49_999
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            clr,
    output logic [MS_W-1:0] ms
);

    logic [PRESC_W-1:0] presc;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            presc <= '0;
            ms    <= '0;
        end else if (presc == T1MS) begin
            presc <= '0;
            if (ms != '1) ms <= ms + MS_W'(1);
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/morse_key_decoder.sv
// morse_key_decoder: times presses/releases of an active-low key and decodes S / O.
// Build option: define MORSE_DEBOUNCE_EN to insert a debounce filter after the
// synchronizer (stability window MIN_PRESS_MS/2 ms).
// Ports:
//   CLK        in   system clock
//   RST        in   synchronous active-high reset
//   Key_In     in   asynchronous key level, 0 = pressed
//   Sym_Valid  out  one-cycle pulse, decoded symbol available
//   Sym_Code   out  2'b10 = S, 2'b01 = O, 2'b00 = invalid (meaningful with Sym_Valid)
//   Sym_Err    out  one-cycle pulse with Sym_Valid when the character is invalid
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter logic [PRESC_W-1:0] T1MS         = 16'd49_999,
    parameter int unsigned        MIN_PRESS_MS = 20,
    parameter int unsigned        DASH_MIN_MS  = 250,
    parameter int unsigned        MAX_PRESS_MS = 1000,
    parameter int unsigned        CHAR_GAP_MS  = 200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Key_In,
    output logic       Sym_Valid,
    output logic [1:0] Sym_Code,
    output logic       Sym_Err
);

    // Two-flop synchronizer, resets to released
    logic key_m, key_s;
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_m <= 1'b1;
            key_s <= 1'b1;
        end else begin
            key_m <= Key_In;
            key_s <= key_m;
        end
    end

    logic key_f;

`ifdef MORSE_DEBOUNCE_EN
    localparam int unsigned DB_MS = MIN_PRESS_MS / 2;

    logic            key_db;
    logic [MS_W-1:0] db_ms;
    logic            db_accept_c;
    logic            db_clr_c;

    // Timer runs only while the input differs from the accepted level; it is also
    // cleared on acceptance so a bounce right after a change restarts the window.
    assign db_accept_c = (key_s != key_db) && (db_ms >= MS_W'(DB_MS));
    assign db_clr_c    = (key_s == key_db) || db_accept_c;

    morse_ms_timer #(.T1MS(T1MS)) u_db_timer (
        .CLK (CLK),
        .RST (RST),
        .clr (db_clr_c),
        .ms  (db_ms)
    );

    always_ff @(posedge CLK) begin
        if (RST)              key_db <= 1'b1;
        else if (db_accept_c) key_db <= key_s;
    end

    assign key_f = key_db;
`else
    assign key_f = key_s;
`endif

    morse_state_t     state;
    logic [MS_W-1:0]  ms;
    logic [2:0]       pattern;
    logic [CNT_W-1:0] count;
    logic             bad;
    logic             gap_done_c;
    logic             tmr_clr_c;
    logic [CNT_W-1:0] count_inc_c;
    logic [1:0]       code_c;

    assign gap_done_c  = (ms == MS_W'(CHAR_GAP_MS));
    assign count_inc_c = (count == CNT_W'(4)) ? count : count + CNT_W'(1);
    assign code_c      = decode_char(count, pattern, bad);

    // Timer is held clear in IDLE/EMIT and cleared on every transition out of
    // PRESS or GAP, so each duration starts from zero.
    always_comb begin
        tmr_clr_c = 1'b1;
        case (state)
            ST_PRESS: tmr_clr_c = key_f;
            ST_GAP:   tmr_clr_c = !key_f || gap_done_c;
            default:  tmr_clr_c = 1'b1;
        endcase
    end

    morse_ms_timer #(.T1MS(T1MS)) u_ms_timer (
        .CLK (CLK),
        .RST (RST),
        .clr (tmr_clr_c),
        .ms  (ms)
    );

    // Decoder FSM with registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            pattern   <= '0;
            count     <= '0;
            bad       <= 1'b0;
            Sym_Valid <= 1'b0;
            Sym_Code  <= SYM_NONE;
            Sym_Err   <= 1'b0;
        end else begin
            Sym_Valid <= 1'b0;
            Sym_Code  <= SYM_NONE;
            Sym_Err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!key_f) state <= ST_PRESS;
                end
                ST_PRESS: begin
                    if (key_f) begin
                        if (ms < MS_W'(MIN_PRESS_MS)) begin
                            state <= (count != '0) ? ST_GAP : ST_IDLE;
                        end else begin
                            state <= ST_GAP;
                            count <= count_inc_c;
                            if (ms < MS_W'(DASH_MIN_MS))       pattern <= {pattern[1:0], 1'b0};
                            else if (ms <= MS_W'(MAX_PRESS_MS)) pattern <= {pattern[1:0], 1'b1};
                            else                                bad     <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (!key_f) begin
                        state <= ST_PRESS;
                    end else if (gap_done_c) begin
                        state     <= ST_EMIT;
                        Sym_Valid <= 1'b1;
                        Sym_Code  <= code_c;
                        Sym_Err   <= (code_c == SYM_NONE);
                    end
                end
                ST_EMIT: begin
                    pattern <= '0;
                    count   <= '0;
                    bad     <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_key_decoder.sv
// tb_morse_key_decoder: scoreboard bench for morse_key_decoder with T1MS = 9
// (1 ms = 10 cycles). Stimulus tasks push expected symbols computed by a press-list
// model; a separate monitor pops and compares on every Sym_Valid.
module tb_morse_key_decoder;
    import morse_pkg::*;

    localparam logic [15:0] TB_T1MS = 16'd9;
    localparam int CPM       = 10;     // cycles per ms
    localparam int MIN_MS    = 20;
    localparam int DASH_MIN  = 250;
    localparam int MAX_MS    = 1000;
    localparam int CHAR_GAP  = 200;
    localparam int TOL       = 3;
`ifdef MORSE_DEBOUNCE_EN
    localparam int LAT_EXTRA = (MIN_MS / 2) * CPM;
`else
    localparam int LAT_EXTRA = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       Key_In;
    logic       Sym_Valid;
    logic [1:0] Sym_Code;
    logic       Sym_Err;

    morse_key_decoder #(
        .T1MS         (TB_T1MS),
        .MIN_PRESS_MS (MIN_MS),
        .DASH_MIN_MS  (DASH_MIN),
        .MAX_PRESS_MS (MAX_MS),
        .CHAR_GAP_MS  (CHAR_GAP)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Key_In    (Key_In),
        .Sym_Valid (Sym_Valid),
        .Sym_Code  (Sym_Code),
        .Sym_Err   (Sym_Err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] code;
        logic       err;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   presses[$];
    int   last_rel = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void chk(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endfunction

    // Reference: classify each press by its length, then name the character.
    function automatic void model_char(output bit emit, output logic [1:0] code);
        int  n = 0, dots = 0, dashes = 0;
        bit  is_bad = 0;
        foreach (presses[i]) begin
            if (presses[i] < MIN_MS) continue;
            n++;
            if (presses[i] < DASH_MIN)     dots++;
            else if (presses[i] <= MAX_MS) dashes++;
            else                           is_bad = 1;
        end
        emit = (n > 0);
        if (!is_bad && n == 3 && dots == 3)        code = 2'b10;
        else if (!is_bad && n == 3 && dashes == 3) code = 2'b01;
        else                                       code = 2'b00;
    endfunction

    task automatic wait_ms(input int ms);
        repeat (ms * CPM) @(negedge CLK);
    endtask

    task automatic press(input int ms);
        Key_In = 1'b0;
        wait_ms(ms);
        Key_In = 1'b1;
        presses.push_back(ms);
        if (ms >= MIN_MS) last_rel = cyc;
    endtask

    // Close the character: queue the expectation, then hold the key released.
    task automatic end_char(input int ms);
        bit         emit;
        logic [1:0] code;
        model_char(emit, code);
        if (emit) sb.push_back('{code, (code == 2'b00), last_rel + CHAR_GAP * CPM + 4 + LAT_EXTRA});
        presses.delete();
        wait_ms(ms);
    endtask

    task automatic send_same(input int ms, input int n);
        for (int i = 0; i < n; i++) begin
            press(ms);
            if (i != n - 1) wait_ms(GAP_MS);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a symbol
    logic prev_v = 1'b0;
    exp_t e;
    initial begin
        forever begin
            @(negedge CLK);
            if (Sym_Valid === 1'b1) begin
                chk(!prev_v, "valid_pulse_width", 2, 1);
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_symbol", int'(Sym_Code), -1);
                end else begin
                    e = sb.pop_front();
                    chk(Sym_Code === e.code, "sym_code", int'(Sym_Code), int'(e.code));
                    chk(Sym_Err === e.err, "sym_err", int'(Sym_Err), int'(e.err));
                    chk((cyc >= e.at - TOL) && (cyc <= e.at + TOL), "sym_time", cyc, e.at);
                end
            end else if (Sym_Err === 1'b1) begin
                chk(1'b0, "err_without_valid", 1, 0);
            end
            prev_v <= Sym_Valid;
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, n, r, d;
        RST    = 1'b1;
        Key_In = 1'b1;
        repeat (3) @(negedge CLK);
        chk(Sym_Valid === 1'b0, "reset_valid", int'(Sym_Valid), 0);
        chk(Sym_Code === 2'b00, "reset_code", int'(Sym_Code), 0);
        chk(Sym_Err === 1'b0, "reset_err", int'(Sym_Err), 0);
        RST = 1'b0;
        repeat (10) @(negedge CLK);

        // S at generator timing
        send_same(DOT_MS, 3);
        end_char(250);
        // O at generator timing
        send_same(DASH_MS, 3);
        end_char(230);
        // dot dash dot
        press(30); wait_ms(50); press(260); wait_ms(50); press(30);
        end_char(230);
        // four dots: count overflow
        send_same(30, 4);
        end_char(230);
        // glitch in IDLE: nothing
        press(5);
        end_char(230);
        // overlong press: bad element
        press(1200);
        end_char(230);

        // reset mid-dash discards the partial character
        Key_In = 1'b0;
        wait_ms(200);
        RST = 1'b1;
        @(negedge CLK);
        chk(Sym_Valid === 1'b0, "rst_mid_valid", int'(Sym_Valid), 0);
        chk(Sym_Code === 2'b00, "rst_mid_code", int'(Sym_Code), 0);
        chk(Sym_Err === 1'b0, "rst_mid_err", int'(Sym_Err), 0);
        RST = 1'b0;
        presses.delete();
        wait_ms(5);
        Key_In = 1'b1;
        end_char(230);
        // S after reset
        send_same(30, 3);
        end_char(230);

        // randomized characters
        for (int c = 0; c < 3; c++) begin
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                send_same($urandom_range(25, 60), 3);
            end else if (mode == 1) begin
                send_same($urandom_range(255, 290), 3);
            end else begin
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) begin
                    r = $urandom_range(0, 9);
                    if (r < 5)                 d = $urandom_range(25, 60);
                    else if (r < 9 || i == n - 1) d = $urandom_range(255, 290);
                    else                       d = $urandom_range(4, 7);
                    press(d);
                    if (i != n - 1) wait_ms($urandom_range(20, 60));
                end
            end
            end_char(230);
        end

        wait_ms(20);
        chk(sb.size() == 0, "pending_symbols", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
